writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage (MEM/WB boundary); registers the memory-stage result, selects the write-back source and formats load data.
- Drives the register file write port (rd, data, write enable) directly.
- Keeps a 64-bit retired-instruction counter for debug and performance readout.

Parameters:
- DWIDTH, 32, datapath width in bits.
- CNTWIDTH, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- valid_i  input  1  memory stage presents a valid instruction.
- stall_i  input  1  hold current contents; upstream is frozen.
- flush_i  input  1  squash current and incoming contents.
- pc_i  input  DWIDTH  PC of the incoming instruction.
- alu_res_i  input  DWIDTH  ALU result; bits [1:0] are the load byte offset.
- memrd_data_i  input  DWIDTH  raw aligned word from data memory.
- funct3_i  input  3  load size/sign code.
- wbsel_i  input  2  write-back source select.
- rd_i  input  5  destination register.
- regwren_i  input  1  instruction writes rd.
- rd_o  output  5  register file rd.
- datawb_o  output  DWIDTH  register file write data.
- regwren_o  output  1  register file write enable.
- valid_o  output  1  stage holds a valid instruction.
- retired_o  output  CNTWIDTH  count of instructions captured into the stage.

Behaviour:
- Reset: async; all outputs and internal state go to 0 immediately, including mid-cycle. Internal state is valid_q, regwren_q, rd_q, data_q, done_q and the counter.
- Latency: 1 cycle. Source selection and load formatting happen before the register, so all outputs come straight from flops.
- Source select (wbsel_i):
  - 00: alu_res_i.
  - 01: formatted load.
  - 10: pc_i + 4, modulo 2^DWIDTH, so 0xFFFFFFFC gives 0.
  - 11: 0.
- Load formatting, with off = alu_res_i[1:0]:
  - 000 LB: byte at off, sign-extended.
  - 001 LH: halfword at off[1], sign-extended; off[0] is ignored.
  - 010 LW: whole word.
  - 100 LBU: byte at off, zero-extended.
  - 101 LHU: halfword at off[1], zero-extended.
  - Any other code: treated as LW.
- Per rising edge, priority flush > stall > advance:
  - flush_i: valid_q=0, regwren_q=0, done_q=0; counter unchanged.
  - stall_i: all fields held; done_q=1 if valid_q.
  - advance: capture all inputs; valid_q=valid_i; done_q=0; counter += 1 when valid_i=1.
- regwren_o = valid_q & regwren_q & (rd_q != 0) & ~done_q.
  - Each instruction writes exactly once, even if held over several stall cycles.
  - rd=0 never asserts a write.
- rd_o, datawb_o and valid_o reflect held state whether or not regwren_o is asserted.
- Bubble (valid_i=0 on advance): valid_o=0, regwren_o=0, and data fields still capture but are don't-care.
- Counter wraps from 2^CNTWIDTH-1 to 0 with no saturation.
- flush_i and stall_i asserted in the same cycle: flush wins and the held instruction is dropped without writing again.

Decomposition:
- Shared constants package (constants.svh):
  - WB_SEL_ALU/MEM/PC4 encodings.
  - LOAD_LB/LH/LW/LBU/LHU funct3 codes.
  - Reset value constants.
- Sub-module load_extend: purely combinational (word, off, funct3) -> formatted DWIDTH value. It is unit-testable on its own.
- The stage itself holds the select mux, pipeline register, one-shot write flag and counter.

Test Plan:
- Reset: assert rst mid-cycle with valid data captured -> all outputs 0 immediately, retired_o=0.
- ALU path: valid, wbsel=00, alu=0x12345678, rd=5, regwren=1 -> next cycle rd_o=5, datawb_o=0x12345678, regwren_o=1, retired_o=1.
- Loads with memrd_data_i=0x80F1A27F:
  - LB, off=3 -> 0xFFFFFF80.
  - LBU, off=1 -> 0x000000A2.
  - LH, off=2 -> 0xFFFF80F1.
  - LHU, off=1 -> 0x0000A27F.
  - LW -> 0x80F1A27F.
- JAL link: wbsel=10, pc=0x00001000 -> datawb_o=0x00001004; pc=0xFFFFFFFC -> 0x00000000.
- Stall: capture instr (rd=7), then stall 3 cycles -> regwren_o high only the first cycle; rd_o/datawb_o held; retired_o increments once.
- Flush and x0:
  - flush+stall together -> valid_o=0, regwren_o=0, counter unchanged.
  - rd=0 with regwren=1, data 0xDEADBEEF -> regwren_o=0 while valid_o=1.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the write-back stage: source selects, load funct3 codes
// and the reset values of the pipeline register fields.
package writeback_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_ZERO = 2'b11;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic       RST_VALID   = 1'b0;
    localparam logic       RST_REGWREN = 1'b0;
    localparam logic       RST_DONE    = 1'b0;
    localparam logic [4:0] RST_RD      = 5'd0;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load formatter: picks the byte/halfword addressed by the low
// address bits out of an aligned word and sign- or zero-extends it.
module load_extend
    import writeback_stage_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] word_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        funct3_i,
    output logic [DWIDTH-1:0] data_o
);

    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane[gi] = word_i[gi*8 +: 8];
    end

    assign w_byte = w_lane[off_i];
    // Halfword loads ignore off_i[0]: only the upper/lower half is selectable.
    assign w_half = off_i[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            LOAD_LB:  data_o = {{(DWIDTH-8){w_byte[7]}}, w_byte};
            LOAD_LH:  data_o = {{(DWIDTH-16){w_half[15]}}, w_half};
            LOAD_LBU: data_o = {{(DWIDTH-8){1'b0}}, w_byte};
            LOAD_LHU: data_o = {{(DWIDTH-16){1'b0}}, w_half};
            default:  data_o = word_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register: selects the write-back value, drives the register
// file write port once per instruction and counts captured instructions.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int CNTWIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic [DWIDTH-1:0]   pc_i,
    input  logic [DWIDTH-1:0]   alu_res_i,
    input  logic [DWIDTH-1:0]   memrd_data_i,
    input  logic [2:0]          funct3_i,
    input  logic [1:0]          wbsel_i,
    input  logic [4:0]          rd_i,
    input  logic                regwren_i,
    output logic [4:0]          rd_o,
    output logic [DWIDTH-1:0]   datawb_o,
    output logic                regwren_o,
    output logic                valid_o,
    output logic [CNTWIDTH-1:0] retired_o
);

    logic [DWIDTH-1:0]   w_load;
    logic [DWIDTH-1:0]   w_pc4;
    logic [DWIDTH-1:0]   w_wbdata;

    logic                r_valid;
    logic                r_regwren;
    logic                r_done;
    logic [4:0]          r_rd;
    logic [DWIDTH-1:0]   r_data;
    logic [CNTWIDTH-1:0] r_retired;

    load_extend #(
        .DWIDTH (DWIDTH)
    ) u_load_extend (
        .word_i   (memrd_data_i),
        .off_i    (alu_res_i[1:0]),
        .funct3_i (funct3_i),
        .data_o   (w_load)
    );

    assign w_pc4 = pc_i + DWIDTH'(4);

    always_comb begin
        w_wbdata = '0;
        case (wbsel_i)
            WB_SEL_ALU: w_wbdata = alu_res_i;
            WB_SEL_MEM: w_wbdata = w_load;
            WB_SEL_PC4: w_wbdata = w_pc4;
            default:    w_wbdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= RST_VALID;
            r_regwren <= RST_REGWREN;
            r_done    <= RST_DONE;
            r_rd      <= RST_RD;
            r_data    <= '0;
            r_retired <= '0;
        end else if (flush_i) begin
            r_valid   <= 1'b0;
            r_regwren <= 1'b0;
            r_done    <= 1'b0;
        end else if (stall_i) begin
            // The held instruction already had its write cycle; suppress repeats.
            if (r_valid) begin
                r_done <= 1'b1;
            end
        end else begin
            r_valid   <= valid_i;
            r_regwren <= regwren_i;
            r_done    <= 1'b0;
            r_rd      <= rd_i;
            r_data    <= w_wbdata;
            if (valid_i) begin
                r_retired <= r_retired + CNTWIDTH'(1);
            end
        end
    end

    assign regwren_o = r_valid & r_regwren & (r_rd != 5'd0) & ~r_done;
    assign rd_o      = r_rd;
    assign datawb_o  = r_data;
    assign valid_o   = r_valid;
    assign retired_o = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a randomized
// run against an instruction-level reference model.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] pc_i;
    logic [31:0] alu_res_i;
    logic [31:0] memrd_data_i;
    logic [2:0]  funct3_i;
    logic [1:0]  wbsel_i;
    logic [4:0]  rd_i;
    logic        regwren_i;
    logic [4:0]  rd_o;
    logic [31:0] datawb_o;
    logic        regwren_o;
    logic        valid_o;
    logic [63:0] retired_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the instruction currently held by the stage.
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_pend;
    logic [63:0] m_cnt;

    writeback_stage #(
        .DWIDTH   (32),
        .CNTWIDTH (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .pc_i         (pc_i),
        .alu_res_i    (alu_res_i),
        .memrd_data_i (memrd_data_i),
        .funct3_i     (funct3_i),
        .wbsel_i      (wbsel_i),
        .rd_i         (rd_i),
        .regwren_i    (regwren_i),
        .rd_o         (rd_o),
        .datawb_o     (datawb_o),
        .regwren_o    (regwren_o),
        .valid_o      (valid_o),
        .retired_o    (retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_wb(input logic [1:0] sel, input logic [2:0] f3,
                                           input logic [31:0] alu, input logic [31:0] mem,
                                           input logic [31:0] pc);
        longint off, b, h, r;
        off = longint'(alu) % 4;
        b   = (longint'(mem) >> (8 * off)) & 'hFF;
        h   = (longint'(mem) >> (16 * (off / 2))) & 'hFFFF;
        r   = 0;
        case (sel)
            2'd0: r = longint'(alu);
            2'd1: begin
                if (f3 == 3'd0)      r = (b >= 128) ? b - 256 : b;
                else if (f3 == 3'd1) r = (h >= 32768) ? h - 65536 : h;
                else if (f3 == 3'd4) r = b;
                else if (f3 == 3'd5) r = h;
                else                 r = longint'(mem);
            end
            2'd2: r = (longint'(pc) + 4) % 64'h1_0000_0000;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_rd    = 5'd0;
        m_data  = 32'd0;
        m_pend  = 1'b0;
        m_cnt   = 64'd0;
    endtask

    // Drive one cycle of inputs, clock it in and update the model; returns at edge+1.
    task automatic cycle(input logic v, input logic st, input logic fl,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [2:0] f3, input logic [1:0] sel,
                         input logic [4:0] rd, input logic wr);
        valid_i      = v;
        stall_i      = st;
        flush_i      = fl;
        pc_i         = pc;
        alu_res_i    = alu;
        memrd_data_i = mem;
        funct3_i     = f3;
        wbsel_i      = sel;
        rd_i         = rd;
        regwren_i    = wr;
        @(posedge clk);
        if (fl) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
        end else if (st) begin
            m_pend = 1'b0;
        end else begin
            m_valid = v;
            m_rd    = rd;
            m_data  = ref_wb(sel, f3, alu, mem, pc);
            m_pend  = wr && (rd != 5'd0);
            if (v) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0, 5'd0, 1'b0);
        model_reset();
        n_checks++;
        if ({valid_o, regwren_o, rd_o, datawb_o, retired_o} !== 103'd0) begin
            n_errors++;
            $display("FAIL reset_hold: got valid=%0b wr=%0b rd=%0d data=%08h ret=%0d, need all 0",
                     valid_o, regwren_o, rd_o, datawb_o, retired_o);
        end
        rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0, 3'd2, 2'd0, 5'd9, 1'b1);
        n_checks++;
        if (valid_o !== 1'b1 || retired_o !== 64'd1 || datawb_o !== 32'hCAFEF00D) begin
            n_errors++;
            $display("FAIL reset_precapture: got valid=%0b ret=%0d data=%08h, need 1/1/cafef00d",
                     valid_o, retired_o, datawb_o);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({valid_o, regwren_o, rd_o, datawb_o, retired_o} !== 103'd0) begin
            n_errors++;
            $display("FAIL reset_midcycle: got valid=%0b wr=%0b rd=%0d data=%08h ret=%0d, need all 0",
                     valid_o, regwren_o, rd_o, datawb_o, retired_o);
        end
        $display("txn reset mid-cycle: valid=%0b retired=%0d", valid_o, retired_o);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678, 32'h0, 3'd2, 2'b00, 5'd5, 1'b1);
        $display("txn alu: rd=%0d data=%08h wr=%0b ret=%0d", rd_o, datawb_o, regwren_o, retired_o);
        n_checks++;
        if (rd_o !== 5'd5 || datawb_o !== 32'h12345678 || regwren_o !== 1'b1 || retired_o !== 64'd1) begin
            n_errors++;
            $display("FAIL alu_path: got rd=%0d data=%08h wr=%0b ret=%0d, need 5/12345678/1/1",
                     rd_o, datawb_o, regwren_o, retired_o);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  off_tab [5] = '{2'd3, 2'd1, 2'd2, 2'd1, 2'd0};
        logic [31:0] exp_tab [5] = '{32'hFFFFFF80, 32'h000000A2, 32'hFFFF80F1, 32'h0000A27F, 32'h80F1A27F};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, {30'h400, off_tab[i]}, 32'h80F1A27F,
                  f3_tab[i], 2'b01, 5'd10 + 5'(i), 1'b1);
            $display("txn load f3=%0d off=%0d: data=%08h", f3_tab[i], off_tab[i], datawb_o);
            n_checks++;
            if (datawb_o !== exp_tab[i] || regwren_o !== 1'b1) begin
                n_errors++;
                $display("FAIL load_%0d: got data=%08h wr=%0b, need %08h wr=1",
                         i, datawb_o, regwren_o, exp_tab[i]);
            end
        end
    endtask

    task automatic test_jal();
        cycle(1'b1, 1'b0, 1'b0, 32'h00001000, 32'h0, 32'h0, 3'd0, 2'b10, 5'd1, 1'b1);
        $display("txn jal pc=00001000: data=%08h", datawb_o);
        n_checks++;
        if (datawb_o !== 32'h00001004) begin
            n_errors++;
            $display("FAIL jal_link: got %08h, need 00001004", datawb_o);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 3'd0, 2'b10, 5'd1, 1'b1);
        $display("txn jal pc=fffffffc: data=%08h", datawb_o);
        n_checks++;
        if (datawb_o !== 32'h00000000) begin
            n_errors++;
            $display("FAIL jal_wrap: got %08h, need 00000000", datawb_o);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h55AA55AA, 32'h0, 3'd0, 2'b11, 5'd2, 1'b1);
        n_checks++;
        if (datawb_o !== 32'h0) begin
            n_errors++;
            $display("FAIL sel_zero: got %08h, need 00000000", datawb_o);
        end
    endtask

    task automatic test_stall();
        logic [63:0] cnt0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A50007, 32'h0, 3'd2, 2'b00, 5'd7, 1'b1);
        cnt0 = retired_o;
        n_checks++;
        if (regwren_o !== 1'b1 || rd_o !== 5'd7 || cnt0 !== m_cnt) begin
            n_errors++;
            $display("FAIL stall_capture: got wr=%0b rd=%0d ret=%0d, need 1/7/%0d",
                     regwren_o, rd_o, cnt0, m_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h11111111, 32'h0, 3'd2, 2'b00, 5'd3, 1'b1);
            $display("txn stall %0d: rd=%0d data=%08h wr=%0b", i, rd_o, datawb_o, regwren_o);
            n_checks++;
            if (regwren_o !== 1'b0 || rd_o !== 5'd7 || datawb_o !== 32'hA5A50007 ||
                retired_o !== cnt0 || valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_hold_%0d: got wr=%0b rd=%0d data=%08h ret=%0d valid=%0b, need 0/7/a5a50007/%0d/1",
                         i, regwren_o, rd_o, datawb_o, retired_o, valid_o, cnt0);
            end
        end
    endtask

    task automatic test_flush_x0();
        logic [63:0] cnt0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h00000042, 32'h0, 3'd2, 2'b00, 5'd8, 1'b1);
        cnt0 = retired_o;
        cycle(1'b1, 1'b1, 1'b1, 32'h0, 32'h00000099, 32'h0, 3'd2, 2'b00, 5'd9, 1'b1);
        $display("txn flush+stall: valid=%0b wr=%0b ret=%0d", valid_o, regwren_o, retired_o);
        n_checks++;
        if (valid_o !== 1'b0 || regwren_o !== 1'b0 || retired_o !== cnt0) begin
            n_errors++;
            $display("FAIL flush_stall: got valid=%0b wr=%0b ret=%0d, need 0/0/%0d",
                     valid_o, regwren_o, retired_o, cnt0);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 3'd2, 2'b00, 5'd0, 1'b1);
        $display("txn x0 write: valid=%0b wr=%0b data=%08h", valid_o, regwren_o, datawb_o);
        n_checks++;
        if (valid_o !== 1'b1 || regwren_o !== 1'b0 || datawb_o !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL x0_write: got valid=%0b wr=%0b data=%08h, need 1/0/deadbeef",
                     valid_o, regwren_o, datawb_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd2, 2'b00, 5'd4, 1'b1);
        n_checks++;
        if (valid_o !== 1'b0 || regwren_o !== 1'b0 || retired_o !== cnt0 + 64'd1) begin
            n_errors++;
            $display("FAIL bubble: got valid=%0b wr=%0b ret=%0d, need 0/0/%0d",
                     valid_o, regwren_o, retired_o, cnt0 + 64'd1);
        end
    endtask

    task automatic test_random();
        logic        v, st, fl, wr;
        logic [31:0] pc;
        logic [4:0]  rd;
        int          bad;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            wr = ($urandom_range(0, 4) != 0);
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            cycle(v, st, fl, pc, $urandom, $urandom, 3'($urandom), 2'($urandom), rd, wr);
            bad = 0;
            if (valid_o !== m_valid || regwren_o !== (m_valid && m_pend) || retired_o !== m_cnt) bad = 1;
            if (m_valid && (rd_o !== m_rd || datawb_o !== m_data)) bad = 1;
            n_checks++;
            if (bad != 0) begin
                n_errors++;
                $display("FAIL random_%0d: got valid=%0b wr=%0b rd=%0d data=%08h ret=%0d, need valid=%0b wr=%0b rd=%0d data=%08h ret=%0d",
                         i, valid_o, regwren_o, rd_o, datawb_o, retired_o,
                         m_valid, m_valid && m_pend, m_rd, m_data, m_cnt);
            end
        end
        $display("txn random: 400 cycles, retired=%0d", retired_o);
    endtask

    initial begin
        rst          = 1'b1;
        valid_i      = 1'b0;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        pc_i         = '0;
        alu_res_i    = '0;
        memrd_data_i = '0;
        funct3_i     = '0;
        wbsel_i      = '0;
        rd_i         = '0;
        regwren_i    = 1'b0;
        model_reset();
        test_reset();
        test_alu();
        test_loads();
        test_jal();
        test_stall();
        test_flush_x0();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
